// File: rtl/trng_pkg.sv
// trng_pkg: shared types and width helpers for the TRNG entropy harvester.
//   vn_state_t  - von Neumann debias stage state
//   cnt_w()     - prescaler counter width for a strobe period
//   bit_cnt_w() - collector bit-count width, able to hold the value W
package trng_pkg;

   typedef enum logic {VN_IDLE = 1'b0, VN_HAVE = 1'b1} vn_state_t;

   function automatic int cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

   function automatic int bit_cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: one von Neumann debias stage. Raw samples are taken in
// pairs on strobe; a differing pair emits its first sample, an equal pair
// emits nothing.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   strobe    - sample the raw bit this cycle
//   raw       - raw (biased) entropy bit
//   clear     - synchronous return to VN_IDLE, suppresses output
//   bit_vld   - vn_bit is a debiased bit this cycle (combinational)
//   vn_bit    - debiased bit value
module trng_vn_debias
   import trng_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic raw,
   input  logic clear,
   output logic bit_vld,
   output logic vn_bit
);

   vn_state_t state;
   logic      first;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= VN_IDLE;
      end else if (clear) begin
         state <= VN_IDLE;
      end else if (strobe) begin
         state <= (state == VN_IDLE) ? VN_HAVE : VN_IDLE;
      end
   end

   // Sample holder is pure data; its value only matters once state is VN_HAVE.
   always_ff @(posedge clk) begin
      if (strobe && !clear && state == VN_IDLE)
         first <= raw;
   end

   assign bit_vld = strobe && !clear && (state == VN_HAVE) && (raw != first);
   assign vn_bit  = first;

endmodule

// File: rtl/trng_harvester.sv
// trng_harvester: multi-channel entropy harvester. Synchronises N_CH raw
// entropy bits, samples them every DIV clocks, XOR-combines the masked
// channels, debiases with a von Neumann stage and packs W-bit words onto a
// valid/ready output.
// Optional feature macro: TRNG_HEALTH_EN adds a repetition-count health test
// with a sticky health_fail alarm; without it health_fail is tied to 0.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - harvester enable (0 discards the partial word)
//   ent_in       - raw entropy bits, asynchronous to clk
//   ch_mask      - 1 = channel contributes to the XOR
//   rnd_data     - output word, first collected bit at the MSB
//   rnd_valid    - rnd_data holds an unread word
//   rnd_ready    - consumer accepts the word
//   busy         - en && !health_fail
//   health_fail  - sticky health alarm
module trng_harvester
   import trng_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int W         = 8,
   parameter int DIV       = 4,
   parameter int RCT_LIMIT = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N_CH-1:0] ent_in,
   input  logic [N_CH-1:0] ch_mask,
   output logic [W-1:0]    rnd_data,
   output logic            rnd_valid,
   input  logic            rnd_ready,
   output logic            busy,
   output logic            health_fail
);

   localparam int CNT_W = cnt_w(DIV);
   localparam int BC_W  = bit_cnt_w(W);

   logic [N_CH-1:0]  sync_p0, sync_p1;
   logic [CNT_W-1:0] pre_cnt;
   logic             strobe, raw;
   logic [W-1:0]     sh;
   logic [BC_W-1:0]  bit_cnt;
   logic             full, can_xfer, stall, xfer;
   logic             vn_strobe, vn_clear, bit_vld, vn_bit;

   // Stage p0/p1: two-flop synchroniser for the asynchronous entropy inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= ent_in;
         sync_p1 <= sync_p0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre_cnt <= '0;
      else if (!en)
         pre_cnt <= '0;
      else if (pre_cnt == CNT_W'(DIV - 1))
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   assign strobe = en && (pre_cnt == CNT_W'(DIV - 1));
   assign raw    = ^(sync_p1 & ch_mask);

   // A full word that cannot move to the output freezes the whole bit path.
   assign full      = (bit_cnt == BC_W'(W));
   assign can_xfer  = !rnd_valid || rnd_ready;
   assign stall     = full && !can_xfer;
   assign vn_clear  = !en || health_fail;
   assign vn_strobe = strobe && !stall;
   assign xfer      = full && can_xfer && !vn_clear;

   trng_vn_debias u_vn (
      .clk     (clk),
      .rst     (rst),
      .strobe  (vn_strobe),
      .raw     (raw),
      .clear   (vn_clear),
      .bit_vld (bit_vld),
      .vn_bit  (vn_bit)
   );

   // Stage p2: collector; a bit arriving while the full word leaves starts the next word
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bit_cnt <= '0;
      else if (vn_clear)
         bit_cnt <= '0;
      else if (xfer)
         bit_cnt <= bit_vld ? BC_W'(1) : '0;
      else if (bit_vld)
         bit_cnt <= bit_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (health_fail)
         sh <= '0;
      else if (bit_vld)
         sh <= {sh[W-2:0], vn_bit};
   end

   // Output register: reload may coincide with acceptance, keeping rnd_valid high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_data  <= '0;
         rnd_valid <= 1'b0;
      end else if (health_fail) begin
         rnd_data  <= '0;
         rnd_valid <= 1'b0;
      end else if (xfer) begin
         rnd_data  <= sh;
         rnd_valid <= 1'b1;
      end else if (rnd_ready) begin
         rnd_valid <= 1'b0;
      end
   end

`ifdef TRNG_HEALTH_EN
   localparam int RCT_W = $clog2(RCT_LIMIT + 1);

   logic [RCT_W-1:0] rct_cnt, rct_nxt;
   logic             rct_last, hf_q;

   // A zero count marks "no previous sample", so the first sample reloads to 1.
   always_comb begin
      rct_nxt = RCT_W'(1);
      if (rct_cnt != '0 && raw == rct_last)
         rct_nxt = (rct_cnt == RCT_W'(RCT_LIMIT)) ? rct_cnt : rct_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rct_cnt  <= '0;
         rct_last <= 1'b0;
         hf_q     <= 1'b0;
      end else if (!en) begin
         rct_cnt <= '0;
      end else if (strobe && !hf_q) begin
         rct_cnt  <= rct_nxt;
         rct_last <= raw;
         if (rct_nxt == RCT_W'(RCT_LIMIT))
            hf_q <= 1'b1;
      end
   end

   assign health_fail = hf_q;
`else
   assign health_fail = 1'b0;
`endif

   assign busy = en && !health_fail;

endmodule

// File: tb/tb_trng_harvester.sv
// tb_trng_harvester: directed self-checking bench for trng_harvester
// (N_CH=4, W=8, DIV=4). Entropy values are applied one per strobe period;
// idle gaps are always two strobe periods with ent_in held, so the von Neumann
// stage sees an equal pair and stays aligned.
module tb_trng_harvester;

`ifdef TRNG_HEALTH_EN
   localparam logic HEALTH = 1'b1;
`else
   localparam logic HEALTH = 1'b0;
`endif

   logic       clk, rst, en, rnd_valid, rnd_ready, busy, health_fail;
   logic [3:0] ent_in, ch_mask;
   logic [7:0] rnd_data;
   int         total, bad;

   trng_harvester #(.N_CH(4), .W(8), .DIV(4), .RCT_LIMIT(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .ent_in      (ent_in),
      .ch_mask     (ch_mask),
      .rnd_data    (rnd_data),
      .rnd_valid   (rnd_valid),
      .rnd_ready   (rnd_ready),
      .busy        (busy),
      .health_fail (health_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   // One value per strobe period; the strobe lands on the 4th edge.
   task automatic feed_raw(input logic [3:0] v);
      ent_in = v;
      hold(4);
   endtask

   task automatic emit_bit(input logic b, input logic dual);
      feed_raw(dual ? {2'b00, b, b} : {3'b000, b});
      feed_raw(dual ? {2'b00, ~b, ~b} : {3'b000, ~b});
   endtask

   task automatic emit_word(input logic [7:0] w, input logic dual);
      for (int i = 7; i >= 0; i--) emit_bit(w[i], dual);
   endtask

   task automatic pulse_ready();
      rnd_ready = 1'b1;
      tick();
      rnd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; ent_in = '0; ch_mask = '0; rnd_ready = 1'b0;
      hold(3);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
      total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rnd_data); end
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_hf got=%b exp=0", health_fail); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_word();
      en = 1'b1; ch_mask = 4'b0001; rnd_ready = 1'b0;
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL word_busy got=%b exp=1", busy); end
      hold(7);
      emit_word(8'h55, 1'b0);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL word_latency got=%b exp=0", rnd_valid); end
      tick();
      total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL word_valid got=%b exp=1", rnd_valid); end
      total++; if (rnd_data !== 8'h55) begin bad++; $display("FAIL word_data got=%h exp=55", rnd_data); end
      pulse_ready();
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL word_accept got=%b exp=0", rnd_valid); end
      hold(6);
   endtask

   task automatic test_backpressure();
      rnd_ready = 1'b0;
      emit_word(8'hA3, 1'b0);
      tick();
      total++; if (rnd_data !== 8'hA3 || rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%b exp=a3/1", rnd_data, rnd_valid); end
      hold(7);
      emit_word(8'h3C, 1'b0);
      hold(8);
      total++; if (rnd_data !== 8'hA3 || rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_stable got=%h/%b exp=a3/1", rnd_data, rnd_valid); end
      feed_raw(4'b0001); feed_raw(4'b0000); feed_raw(4'b0001); feed_raw(4'b0000);
      total++; if (rnd_data !== 8'hA3) begin bad++; $display("FAIL bp_ignored got=%h exp=a3", rnd_data); end
      pulse_ready();
      total++; if (rnd_data !== 8'h3C || rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_reload got=%h/%b exp=3c/1", rnd_data, rnd_valid); end
      pulse_ready();
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", rnd_valid); end
      hold(6);
   endtask

   task automatic test_even_mask();
      ch_mask = 4'b0011;
      emit_word(8'h55, 1'b1);
      hold(8);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL even_none got=%b exp=0", rnd_valid); end
      ch_mask = 4'b0001;
      emit_word(8'h55, 1'b1);
      tick();
      total++; if (rnd_data !== 8'h55 || rnd_valid !== 1'b1) begin bad++; $display("FAIL even_single got=%h/%b exp=55/1", rnd_data, rnd_valid); end
      pulse_ready();
      hold(6);
   endtask

   task automatic test_en_drop();
      emit_word(8'hF0, 1'b0);
      tick();
      hold(7);
      emit_bit(1'b1, 1'b0); emit_bit(1'b0, 1'b0); emit_bit(1'b1, 1'b0);
      emit_bit(1'b0, 1'b0); emit_bit(1'b1, 1'b0);
      en = 1'b0;
      hold(3);
      total++; if (rnd_data !== 8'hF0 || rnd_valid !== 1'b1) begin bad++; $display("FAIL en_pending got=%h/%b exp=f0/1", rnd_data, rnd_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy got=%b exp=0", busy); end
      pulse_ready();
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL en_accept got=%b exp=0", rnd_valid); end
      en = 1'b1;
      emit_word(8'h0F, 1'b0);
      tick();
      total++; if (rnd_data !== 8'h0F || rnd_valid !== 1'b1) begin bad++; $display("FAIL en_fresh got=%h/%b exp=0f/1", rnd_data, rnd_valid); end
      pulse_ready();
      hold(6);
   endtask

   task automatic test_constant();
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; ch_mask = 4'b0001; rnd_ready = 1'b1;
      for (int i = 0; i < 31; i++) feed_raw(4'hF);
      total++; if (health_fail !== 1'b0 || rnd_valid !== 1'b0) begin bad++; $display("FAIL const_31 got=%b/%b exp=0/0", health_fail, rnd_valid); end
      feed_raw(4'hF);
      total++; if (health_fail !== HEALTH) begin bad++; $display("FAIL const_hf got=%b exp=%b", health_fail, HEALTH); end
      total++; if (busy !== !HEALTH) begin bad++; $display("FAIL const_busy got=%b exp=%b", busy, !HEALTH); end
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL const_valid got=%b exp=0", rnd_valid); end
   endtask

   task automatic test_rst_async();
      #2 rst = 1'b1;
      #1;
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL arst_hf got=%b exp=0", health_fail); end
      @(negedge clk);
      rst = 1'b0; en = 1'b1; ch_mask = 4'b0001; rnd_ready = 1'b0;
      emit_word(8'h55, 1'b0);
      tick();
      total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", rnd_valid); end
      hold(7);
      emit_bit(1'b1, 1'b0); emit_bit(1'b1, 1'b0); emit_bit(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", rnd_valid); end
      total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", rnd_data); end
      total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL arst_hf2 got=%b exp=0", health_fail); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_word();
      test_backpressure();
      test_even_mask();
      test_en_drop();
      test_constant();
      test_rst_async();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
